// File: rtl/bram_sdp_fifo_ctrl_if.sv
// Stream-side bundle of the BRAM FIFO controller: the valid/ready write stream,
// the first-word-fall-through read stream and the occupancy count.
// The controller uses the slave view; the producer/consumer side uses master.
interface bram_sdp_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
) ();
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic [ADDR_WIDTH+1:0] count;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, count
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, count
    );
endinterface

// File: rtl/bram_sdp_fifo_ctrl.sv
// FIFO controller for an external simple-dual-port BRAM with a 1-cycle
// registered read. Words are written straight into the BRAM; a read is issued
// whenever the 2-entry output stage (head + skid) will have room for the
// returning word, which hides the read latency and sustains 1 word/cycle.
module bram_sdp_fifo_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    bram_sdp_fifo_ctrl_if.slave   bus,
    output logic                  wce,
    output logic [ADDR_WIDTH-1:0] wa,
    output logic [DATA_WIDTH-1:0] wd,
    output logic                  rce,
    output logic [ADDR_WIDTH-1:0] ra,
    input  logic [DATA_WIDTH-1:0] rq
);

    // Write/read pointers wrap silently modulo the BRAM depth.
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    // Words resident in the BRAM, 0..DEPTH; the MSB set means exactly DEPTH.
    logic [ADDR_WIDTH:0]   bram_cnt;
    // A read was issued last cycle, so rq carries a word this cycle.
    logic                  rd_inflight;
    // Output stage occupancy 0..2 and its two registers.
    logic [1:0]            out_cnt;
    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] skid_q;

    logic                  s_ready_i;
    logic                  m_valid_i;
    logic                  push;
    logic                  pop;
    logic                  issue;
    logic [2:0]            stage_occ;

    // Handshakes and the read-issue decision, all gated off during reset.
    always_comb begin
        s_ready_i = ~rst & ~bram_cnt[ADDR_WIDTH];
        m_valid_i = ~rst & (out_cnt != 2'd0);
        push      = bus.s_valid & s_ready_i;
        pop       = m_valid_i & bus.m_ready;
        // Entries the output stage must hold after this edge if nothing new is
        // issued: current contents plus the word on rq, minus the one leaving.
        stage_occ = {1'b0, out_cnt} + {2'b00, rd_inflight} - {2'b00, pop};
        issue     = ~rst & (bram_cnt != '0) & (stage_occ < 3'd2);
    end

    assign bus.s_ready = s_ready_i;
    assign bus.m_valid = m_valid_i;
    assign bus.m_data  = rst ? '0 : head_q;
    assign bus.count   = rst ? '0
                       : {1'b0, bram_cnt}
                         + (ADDR_WIDTH+2)'(rd_inflight)
                         + (ADDR_WIDTH+2)'(out_cnt);

    assign wce = push;
    assign wa  = wr_ptr;
    assign wd  = bus.s_data;
    assign rce = issue;
    assign ra  = rd_ptr;

    // BRAM bookkeeping: pointers, resident count and the read-in-flight flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            bram_cnt    <= '0;
            rd_inflight <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, issue})
                2'b10:   bram_cnt <= bram_cnt + 1'b1;
                2'b01:   bram_cnt <= bram_cnt - 1'b1;
                default: bram_cnt <= bram_cnt;
            endcase
            // A read issued before reset is dropped because this clears first.
            rd_inflight <= issue;
        end
    end

    // Output stage occupancy: landing word in, popped word out.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_cnt <= 2'd0;
        end else begin
            case ({pop, rd_inflight})
                2'b10:   out_cnt <= out_cnt - 2'd1;
                2'b01:   out_cnt <= out_cnt + 2'd1;
                default: out_cnt <= out_cnt;
            endcase
        end
    end

    // Output stage data: the landing word goes to head if head is empty or
    // leaving this edge, otherwise to skid; a pop promotes skid to head.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
        end else begin
            case ({pop, rd_inflight})
                2'b11: begin
                    if (out_cnt == 2'd2) begin
                        head_q <= skid_q;
                        skid_q <= rq;
                    end else begin
                        head_q <= rq;
                    end
                end
                2'b10: begin
                    if (out_cnt == 2'd2) begin
                        head_q <= skid_q;
                    end
                end
                2'b01: begin
                    if (out_cnt == 2'd0) begin
                        head_q <= rq;
                    end else begin
                        skid_q <= rq;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
